// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the buffered UART transmitter.
// Master drives writes; slave reports FIFO flags and line state.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic                 busy;
    logic                 tx_done;
    logic                 tx_pin;

    modport master (
        output wr_en, wr_data,
        input  full, empty, overflow, busy, tx_done, tx_pin
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, overflow, busy, tx_done, tx_pin
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with parametrised frame format.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_ODD   = 0
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [PTR_W:0]       fcnt_q, fcnt_d;
    logic                 full_q, empty_q, ovf_q;
    logic                 push, pop;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pin;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // full is sampled before any same-cycle pop, so writes while full drop
    assign push   = bus.wr_en & ~full_q;
    assign wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    assign rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    assign fcnt_d = fcnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            full_q  <= (fcnt_d == DEPTH);
            empty_q <= (fcnt_d == '0);
            if (bus.wr_en && full_q) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // back-to-back frames: reload straight into START, no idle bit
                if (baud_q == STOP_LAST) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = (^mem_q[rptr_q]) ^ (PARITY_ODD != 0);
`endif
        end
    end

    always_comb begin
        pin = 1'b1;
        unique case (state_q)
            S_START:  pin = 1'b0;
            S_DATA:   pin = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: pin = par_q;
`endif
            default:  pin = 1'b1;
        endcase
    end

    assign bus.tx_pin   = pin;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.tx_done  = (state_q == S_STOP) && (baud_q == STOP_LAST);
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO, succeeding the fixed 8N1 single-byte transmitter on the iCE40-HX8K board. Generalises frame format (data bits, stop bits, optional parity) and bit timing via parameters. Buffers bytes so back-to-back frames leave with no idle gap. Sits between user logic (byte producer) and the board's tx_pin.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (12 MHz / 115200); legal >= 2
DATA_BITS, 8, data bits per frame; legal 5..9
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  DATA_BITS  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
overflow  output  1  sticky: set when wr_en asserted while full
busy  output  1  high while a frame is on the line (state != IDLE)
tx_done  output  1  one-cycle pulse on the final cycle of each frame's last stop bit
tx_pin  output  1  serial line, idle high

Behaviour:
- Reset (async, rst=1): tx_pin=1, busy=0, tx_done=0, full=0, empty=1, overflow=0, FIFO pointers/count=0, baud counter=0, state=IDLE. FIFO contents undefined.
- FIFO: count range 0..FIFO_DEPTH, pointers wrap modulo FIFO_DEPTH. full/empty are registered from count.
- Write: accepted when wr_en=1 and full=0. wr_en=1 with full=1 drops the data and sets overflow (cleared only by rst). full is sampled before any same-cycle pop, so a write while full is rejected even if a pop occurs that cycle.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged.
- Pop: FSM pops only when empty=0. Data written into an empty FIFO is poppable the next cycle at the earliest.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_pin=1. If empty=0, pop into shift register and go to START. The first START cycle follows the pop cycle, so line latency from the first write into an empty FIFO is 2 cycles.
- START: tx_pin=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: DATA_BITS bits, LSB first, each held exactly CLKS_PER_BIT cycles. Then PARITY if enabled, else STOP.
- PARITY: one bit for CLKS_PER_BIT cycles (see Optional Feature), then STOP.
- STOP: tx_pin=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: tx_done=1. Same cycle: if empty=0, pop and go to START (no idle bit between frames); else go to IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- busy=1 in START, DATA, PARITY, STOP.
- Reset mid-frame: line returns high immediately (async) and queued data is discarded.
- Baud counter width: $clog2(CLKS_PER_BIT*STOP_BITS); counter reloads at each bit boundary.

Optional Feature:
UART_TX_PARITY_EN: when defined, a PARITY state is inserted after DATA. The parity bit is the XOR of the data bits, inverted when PARITY_ODD=1. When undefined, there is no PARITY state, no parity logic, and PARITY_ODD is ignored.

Test Plan:
- CLKS_PER_BIT=4, 8N1, write 8'hA5 into empty FIFO -> tx_pin low 2 cycles after write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles, one tx_done pulse, busy=1 for exactly 40 cycles.
- Write 8'h00, 8'hFF in consecutive cycles -> two frames, second start bit immediately after first stop bit (no idle), two tx_done pulses 40 cycles apart.
- FIFO_DEPTH=8, 9 writes with transmitter stalled by prior frame -> full=1 after entry 8, 9th dropped, overflow=1 and stays 1, exactly 8 frames plus the in-flight frame transmitted.
- UART_TX_PARITY_EN, PARITY_ODD=0, byte 8'h07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2, DATA_BITS=7, byte 7'h41 -> stop high 8 cycles, tx_done on last of them.
- Assert rst during DATA of a frame with 3 queued -> tx_pin=1, busy=0, empty=1 immediately; no further frames after release.
